// File: rtl/mem_bist_pkg.sv
// Shared state encoding, mode constants and March C- element table for rw0_mem_bist.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W0,
    RD,
    WR,
    RONLY,
    DRAIN,
    FIN
  } state_t;

  localparam logic MODE_INIT  = 1'b0;
  localparam logic MODE_MARCH = 1'b1;

  typedef logic [2:0] elem_idx_t;

  typedef struct packed {
    logic descending;
    logic exp_val;
    logic write_after;
  } march_elem_t;

  // Elements 1..4 are read-then-write-inverse; element 5 is the final read-only sweep.
  function automatic march_elem_t march_elem(input elem_idx_t idx);
    march_elem_t e;
    case (idx)
      3'd1:    e = '{descending: 1'b0, exp_val: 1'b0, write_after: 1'b1};
      3'd2:    e = '{descending: 1'b0, exp_val: 1'b1, write_after: 1'b1};
      3'd3:    e = '{descending: 1'b1, exp_val: 1'b0, write_after: 1'b1};
      3'd4:    e = '{descending: 1'b1, exp_val: 1'b1, write_after: 1'b1};
      default: e = '{descending: 1'b0, exp_val: 1'b0, write_after: 1'b0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/rw0_port_mux.sv
// Chooses whether the functional requester or the BIST engine drives the RW0 macro port.
module rw0_port_mux #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 256,
  parameter int MASK_WIDTH = 32
) (
  input  logic                  sel_bist,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  input  logic                  f_en,
  input  logic                  f_wmode,
  input  logic [MASK_WIDTH-1:0] f_wmask,
  input  logic [DATA_WIDTH-1:0] f_wdata,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic                  b_en,
  input  logic                  b_wmode,
  input  logic [MASK_WIDTH-1:0] b_wmask,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [ADDR_WIDTH-1:0] RW0_addr,
  output logic                  RW0_en,
  output logic                  RW0_wmode,
  output logic [MASK_WIDTH-1:0] RW0_wmask,
  output logic [DATA_WIDTH-1:0] RW0_wdata
);

  assign RW0_addr  = sel_bist ? b_addr  : f_addr;
  assign RW0_en    = sel_bist ? b_en    : f_en;
  assign RW0_wmode = sel_bist ? b_wmode : f_wmode;
  assign RW0_wmask = sel_bist ? b_wmask : f_wmask;
  assign RW0_wdata = sel_bist ? b_wdata : f_wdata;

endmodule

// File: rtl/rw0_mem_bist.sv
// RW0 SRAM initiator: functional passthrough when idle, zero-init or March C- BIST on start.
// March C- engine and comparator are built only when MEM_BIST_MARCH_EN is defined.
module rw0_mem_bist
  import mem_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 256,
  parameter int MASK_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  input  logic                  f_en,
  input  logic                  f_wmode,
  input  logic [MASK_WIDTH-1:0] f_wmask,
  input  logic [DATA_WIDTH-1:0] f_wdata,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  f_ready,
  output logic [ADDR_WIDTH-1:0] RW0_addr,
  output logic                  RW0_en,
  output logic                  RW0_wmode,
  output logic [MASK_WIDTH-1:0] RW0_wmask,
  output logic [DATA_WIDTH-1:0] RW0_wdata,
  input  logic [DATA_WIDTH-1:0] RW0_rdata
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MIN = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;

  logic                  b_en;
  logic                  b_wmode;
  logic                  b_pat;

`ifdef MEM_BIST_MARCH_EN
  logic                  mode_q, mode_d;
  elem_idx_t             elem_q, elem_d;
  logic                  cmp_valid_q, cmp_valid_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic                  cmp_exp_q, cmp_exp_d;
  march_elem_t           cur_elem;
  march_elem_t           nxt_elem;
  logic                  mismatch;

  assign mismatch = cmp_valid_q && (RW0_rdata != {DATA_WIDTH{cmp_exp_q}});
`else
  // Without the march engine every start is a zero-init, so mode has no effect.
  logic unused_mode;
  assign unused_mode = (mode == MODE_INIT);
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    b_en        = 1'b0;
    b_wmode     = 1'b0;
    b_pat       = 1'b0;
`ifdef MEM_BIST_MARCH_EN
    mode_d      = mode_q;
    elem_d      = elem_q;
    cmp_valid_d = 1'b0;
    cmp_addr_d  = cmp_addr_q;
    cmp_exp_d   = cmp_exp_q;
    cur_elem    = march_elem(elem_q);
    nxt_elem    = march_elem(elem_q + 3'd1);
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = W0;
          addr_d      = ADDR_MIN;
          fail_d      = 1'b0;
          fail_addr_d = '0;
`ifdef MEM_BIST_MARCH_EN
          mode_d      = mode;
          elem_d      = 3'd1;
`endif
        end
      end

      W0: begin
        b_en    = 1'b1;
        b_wmode = 1'b1;
        if (addr_q == ADDR_MAX) begin
          state_d = FIN;
`ifdef MEM_BIST_MARCH_EN
          if (mode_q == MODE_MARCH) begin
            state_d = RD;
            addr_d  = ADDR_MIN;
          end
`endif
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end

`ifdef MEM_BIST_MARCH_EN
      RD: begin
        b_en        = 1'b1;
        cmp_valid_d = 1'b1;
        cmp_addr_d  = addr_q;
        cmp_exp_d   = cur_elem.exp_val;
        state_d     = WR;
      end

      WR: begin
        b_en    = 1'b1;
        b_wmode = 1'b1;
        b_pat   = ~cur_elem.exp_val;
        // Terminal address of the element hands over to the next element's start.
        if (addr_q == (cur_elem.descending ? ADDR_MIN : ADDR_MAX)) begin
          elem_d  = elem_q + 3'd1;
          addr_d  = nxt_elem.descending ? ADDR_MAX : ADDR_MIN;
          state_d = nxt_elem.write_after ? RD : RONLY;
        end else begin
          addr_d  = cur_elem.descending ? (addr_q - 1'b1) : (addr_q + 1'b1);
          state_d = RD;
        end
      end

      RONLY: begin
        b_en        = 1'b1;
        cmp_valid_d = 1'b1;
        cmp_addr_d  = addr_q;
        cmp_exp_d   = cur_elem.exp_val;
        if (addr_q == ADDR_MAX) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end

      DRAIN: state_d = FIN;
`endif

      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef MEM_BIST_MARCH_EN
    // First mismatch latches its address and aborts the run.
    if (mismatch && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = cmp_addr_q;
      state_d     = FIN;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
`ifdef MEM_BIST_MARCH_EN
      mode_q      <= MODE_INIT;
      elem_q      <= 3'd1;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_exp_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
`ifdef MEM_BIST_MARCH_EN
      mode_q      <= mode_d;
      elem_q      <= elem_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_exp_q   <= cmp_exp_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign f_ready   = ~busy;
  assign f_rdata   = RW0_rdata;

  rw0_port_mux #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MASK_WIDTH(MASK_WIDTH)
  ) u_port_mux (
    .sel_bist (busy),
    .f_addr   (f_addr),
    .f_en     (f_en),
    .f_wmode  (f_wmode),
    .f_wmask  (f_wmask),
    .f_wdata  (f_wdata),
    .b_addr   (addr_q),
    .b_en     (b_en),
    .b_wmode  (b_wmode),
    .b_wmask  ({MASK_WIDTH{b_en}}),
    .b_wdata  ({DATA_WIDTH{b_pat}}),
    .RW0_addr (RW0_addr),
    .RW0_en   (RW0_en),
    .RW0_wmode(RW0_wmode),
    .RW0_wmask(RW0_wmask),
    .RW0_wdata(RW0_wdata)
  );

endmodule

// File: tb/tb_rw0_mem_bist.sv
// Bench for rw0_mem_bist with a 16-entry one-cycle-latency RAM model (MEM_BIST_MARCH_EN aware).
module tb_rw0_mem_bist;

  localparam int AW = 4;
  localparam int DW = 256;
  localparam int MW = 32;
`ifdef MEM_BIST_MARCH_EN
  localparam bit MARCH = 1'b1;
`else
  localparam bit MARCH = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, mode;
  logic          busy, done, fail;
  logic [AW-1:0] fail_addr;
  logic [AW-1:0] f_addr;
  logic          f_en, f_wmode;
  logic [MW-1:0] f_wmask;
  logic [DW-1:0] f_wdata, f_rdata;
  logic          f_ready;
  logic [AW-1:0] RW0_addr;
  logic          RW0_en, RW0_wmode;
  logic [MW-1:0] RW0_wmask;
  logic [DW-1:0] RW0_wdata;
  logic [DW-1:0] RW0_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rw0_mem_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
    .f_addr(f_addr), .f_en(f_en), .f_wmode(f_wmode), .f_wmask(f_wmask),
    .f_wdata(f_wdata), .f_rdata(f_rdata), .f_ready(f_ready),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  // RAM model: masked byte-granule writes, registered read, optional stuck-at-1 on bit 5 of addr 3.
  logic [DW-1:0] mem [16];
  logic          stuck_r = 1'b0;
  logic          fa9_seen = 1'b0;

  initial for (int i = 0; i < 16; i++) mem[i] = {8{$urandom}};

  always @(posedge clk) begin
    if (RW0_en) begin
      if (RW0_wmode) begin
        for (int g = 0; g < MW; g++)
          if (RW0_wmask[g]) mem[RW0_addr][g*8 +: 8] <= RW0_wdata[g*8 +: 8];
        if (RW0_addr == 4'd9 && RW0_wdata[7:0] == 8'h5A) fa9_seen <= 1'b1;
      end else begin
        RW0_rdata <= mem[RW0_addr] | ((stuck_r && RW0_addr == 4'd3) ? DW'(32) : '0);
      end
    end
  end

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected BIST access stream, one entry per busy cycle before FIN.
  typedef struct {
    logic          en;
    logic          wr;
    logic [AW-1:0] addr;
    logic          dat;
    logic          mis;
  } acc_t;
  acc_t exp_q[$];

  function automatic void build(input logic march, input logic stuck);
    logic v [16];
    acc_t a;
    logic desc, ev, wa;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      a = '{en: 1'b1, wr: 1'b1, addr: 4'(i), dat: 1'b0, mis: 1'b0};
      exp_q.push_back(a);
      v[i] = 1'b0;
    end
    if (march) begin
      for (int e = 1; e <= 5; e++) begin
        desc = (e == 3 || e == 4);
        ev   = (e == 2 || e == 4);
        wa   = (e != 5);
        for (int k = 0; k < 16; k++) begin
          int ad;
          ad = desc ? 15 - k : k;
          a = '{en: 1'b1, wr: 1'b0, addr: 4'(ad), dat: ev,
                mis: (v[ad] != ev) || (stuck && ad == 3 && !ev)};
          exp_q.push_back(a);
          if (wa) begin
            a = '{en: 1'b1, wr: 1'b1, addr: 4'(ad), dat: ~ev, mis: 1'b0};
            exp_q.push_back(a);
            v[ad] = ~ev;
          end
        end
      end
      a = '{en: 1'b0, wr: 1'b0, addr: '0, dat: 1'b0, mis: 1'b0};
      exp_q.push_back(a);
      // A mismatch is seen one cycle after its read; that cycle's access still goes out.
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i].mis) begin
          while (exp_q.size() > i + 2) void'(exp_q.pop_back());
          break;
        end
      end
    end
  endfunction

  task automatic run_bist(input logic md, input logic stuck, input int glitch_cyc, input int rst_cyc,
                          input logic fsa, input int exp_cyc, input logic exp_fail,
                          input logic [AW-1:0] exp_faddr, input string tag);
    acc_t e;
    logic ew;
    build(md & MARCH, stuck);
    stuck_r = stuck;
    start = 1'b1;
    mode  = md;
    if (fsa) begin
      f_en = 1'b1; f_wmode = 1'b1; f_addr = 4'd9; f_wdata = {32{8'h5A}}; f_wmask = '1;
    end
    #1;
    if (fsa) check("start_fwd", {RW0_en, RW0_wmode, RW0_addr}, {1'b1, 1'b1, 4'd9});
    @(posedge clk); #1;
    start = 1'b0; mode = ~md; f_en = 1'b0;
    for (int cyc = 1; cyc < exp_cyc; cyc++) begin
      if (cyc == rst_cyc) begin
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_fail", {fail, fail_addr}, '0);
        check("rst_done_en", {done, RW0_en}, '0);
        $display("run %s: reset at cycle %0d", tag, cyc);
        return;
      end
      if (cyc == glitch_cyc) begin
        start = 1'b1; mode = ~md;
        f_en = 1'b1; f_wmode = 1'b1; f_addr = 4'd12; f_wdata = '1; f_wmask = '1;
      end
      #1;
      if (cyc == 1) check("flag_clear", {fail, fail_addr}, '0);
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL seq_len: cycle %0d has no expected access, required done at %0d", cyc, exp_cyc);
      end else begin
        e  = exp_q.pop_front();
        ew = e.en & e.wr;
        check($sformatf("acc_c%0d", cyc),
              {RW0_en, RW0_en & RW0_wmode, RW0_en ? RW0_addr : 4'd0,
               ew ? &RW0_wdata : 1'b0, ew ? |RW0_wdata : 1'b0, ew ? &RW0_wmask : 1'b0},
              {e.en, ew, e.en ? e.addr : 4'd0, ew ? e.dat : 1'b0, ew ? e.dat : 1'b0, ew});
      end
      check("busy_run", {busy, done}, 2'b10);
      @(posedge clk); #1;
      start = 1'b0; f_en = 1'b0;
    end
    #1;
    check("fin_done_busy", {done, busy, RW0_en}, 3'b110);
    check("fin_flag", fail, exp_fail);
    check("fin_flag_addr", fail_addr, exp_faddr);
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL seq_len: %0d expected accesses left at done, required 0", exp_q.size());
    end
    @(posedge clk); #1;
    check("post_idle", {busy, done, f_ready}, 3'b001);
    check("post_flag", fail, exp_fail);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_no_en", RW0_en, 1'b0);
    end
    $display("run %s: done at cycle %0d flag=%0b addr=%0d", tag, exp_cyc, fail, fail_addr);
  endtask

  typedef struct {
    logic          en;
    logic          wm;
    logic [AW-1:0] addr;
    logic [MW-1:0] mask;
    logic [DW-1:0] wdata;
    logic          chk;
    logic [DW-1:0] exp;
  } vec_t;

  logic [DW-1:0] rd_q[$];

  task automatic apply_vec(input vec_t v, input int idx);
    f_en = v.en; f_wmode = v.wm; f_addr = v.addr; f_wmask = v.mask; f_wdata = v.wdata;
    #1;
    check("mirror_ctl", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask, f_ready},
          {v.en, v.wm, v.addr, v.mask, 1'b1});
    check("mirror_wdata", RW0_wdata, v.wdata);
    if (v.chk) rd_q.push_back(v.exp);
    @(posedge clk); #1;
    f_en = 1'b0;
    if (v.chk) check($sformatf("f_rdata_v%0d", idx), f_rdata, rd_q.pop_front());
    $display("vec %0d: en=%0b wm=%0b addr=%0d mask=%08h", idx, v.en, v.wm, v.addr, v.mask);
  endtask

  vec_t vt [8];
  vec_t rv;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; mode = 1'b0;
    f_en = 1'b0; f_wmode = 1'b0; f_addr = '0; f_wmask = '0; f_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {busy, done, fail, fail_addr, f_ready, RW0_en}, {4'b0000, 4'b0000, 2'b10});
    reset_n = 1'b1;
    @(posedge clk); #1;

    vt[0] = '{1'b1, 1'b1, 4'd7, 32'h0000000F, {32{8'hA5}}, 1'b0, '0};
    vt[1] = '{1'b1, 1'b0, 4'd7, 32'h0,        '0,          1'b1, {224'h0, 32'hA5A5A5A5}};
    vt[2] = '{1'b1, 1'b1, 4'd2, 32'hFFFFFFFF, {32{8'hFF}}, 1'b0, '0};
    vt[3] = '{1'b1, 1'b0, 4'd2, 32'h0,        '0,          1'b1, {32{8'hFF}}};
    vt[4] = '{1'b1, 1'b1, 4'd7, 32'hF0000000, {32{8'h3C}}, 1'b0, '0};
    vt[5] = '{1'b1, 1'b0, 4'd7, 32'h0,        '0,          1'b1, {32'h3C3C3C3C, 192'h0, 32'hA5A5A5A5}};
    vt[6] = '{1'b1, 1'b0, 4'd0, 32'h0,        '0,          1'b1, '0};
    vt[7] = '{1'b0, 1'b0, 4'd5, 32'h0,        '0,          1'b0, '0};

    // Zero-init with a functional write riding on the start cycle, then read every entry back.
    run_bist(1'b0, 1'b0, 0, 0, 1'b1, 17, 1'b0, 4'd0, "init");
    check("start_access_done", fa9_seen, 1'b1);
    for (int a = 0; a < 16; a++) begin
      rv = '{1'b1, 1'b0, 4'(a), 32'h0, '0, 1'b1, '0};
      apply_vec(rv, 100 + a);
    end

    for (int i = 0; i < 8; i++) apply_vec(vt[i], i);

    run_bist(1'b1, 1'b0, 0, 0, 1'b0, MARCH ? 162 : 17, 1'b0, 4'd0, "march_good");
    run_bist(1'b1, 1'b0, 5, 0, 1'b0, MARCH ? 162 : 17, 1'b0, 4'd0, "march_restart_ignored");
    run_bist(1'b1, 1'b1, 0, 0, 1'b0, MARCH ? 25 : 17, MARCH, MARCH ? 4'd3 : 4'd0, "march_stuck");
    run_bist(1'b1, 1'b0, 0, 0, 1'b0, MARCH ? 162 : 17, 1'b0, 4'd0, "march_after_flag");
    run_bist(1'b1, 1'b1, 0, 0, 1'b0, MARCH ? 25 : 17, MARCH, MARCH ? 4'd3 : 4'd0, "march_stuck2");
    run_bist(1'b1, 1'b0, 0, MARCH ? 91 : 10, 1'b0, MARCH ? 162 : 17, 1'b0, 4'd0, "march_reset");
    stuck_r = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rw0_mem_bist.md
Name: rw0_mem_bist

Overview:
- Initiator for the single-port RW0 SRAM interface: drives RW0_addr/en/wmode/wmask/wdata and samples RW0_rdata.
- Sits between a Chisel-generated cache or TLB controller and its *_ext macro.
- Idle: passes functional accesses straight through. On start, takes the port to zero-initialise the array or run a March C- test, and reports pass/fail with the first failing address.

Parameters:
- ADDR_WIDTH, 9, RW0 address width; array depth N = 2**ADDR_WIDTH.
- DATA_WIDTH, 256, RW0 data width.
- MASK_WIDTH, 32, RW0 write-mask width (one bit per granule).

Ports:
- clk  in  1  single clock for block and macro.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = zero-init, 1 = March C-; sampled with start.
- busy  out  1  BIST owns the port.
- done  out  1  one-cycle pulse at completion.
- fail  out  1  sticky mismatch flag; cleared by next accepted start.
- fail_addr  out  ADDR_WIDTH  address of first mismatch.
- f_addr/f_en/f_wmode/f_wmask/f_wdata  in  ADDR_WIDTH/1/1/MASK_WIDTH/DATA_WIDTH  functional request.
- f_rdata  out  DATA_WIDTH  functional read data.
- f_ready  out  1  equals ~busy.
- RW0_addr/RW0_en/RW0_wmode/RW0_wmask/RW0_wdata  out  as above  to macro.
- RW0_rdata  in  DATA_WIDTH  from macro; valid one cycle after read enable.

Behaviour:
- Reset (reset_n = 0 at clk edge): state IDLE; busy, done, fail = 0; fail_addr = 0; all BIST-side RW0 drives = 0. Array contents undefined after reset.
- IDLE: RW0_* combinationally equal f_*; f_rdata = RW0_rdata always.
- BIST active: f_en ignored, f_rdata undefined. RW0_wmask all ones; wdata all zeros (pattern 0) or all ones (pattern 1).
- Start handshake: start in IDLE → the functional access in that same cycle still executes. Next cycle the FSM enters W0 and busy = 1; fail and fail_addr clear. start while busy is ignored.
- States: IDLE, W0, RD, WR, RONLY, DRAIN, FIN.
- W0: write pattern 0 at addr 0..N-1, one per cycle. Then mode 0 → FIN; mode 1 → RD with element = 1.
- Elements 1..4 alternate RD (read, expect e) and WR (write ~e) per address:
  - 1: ascending, expect 0
  - 2: ascending, expect 1
  - 3: descending, expect 0
  - 4: descending, expect 1
  - Address counter starts at 0 (ascending) or N-1 (descending); wraps to the next element's start after the last address.
- Element 5: RONLY, ascending, expect 0. After addr N-1 → DRAIN, one cycle to compare the last read. Then FIN.
- Compare: registered read address and expected value, compared in the cycle after each read. On mismatch, if fail = 0: set fail, load fail_addr, next state FIN (abort).
- FIN: done = 1 for one cycle, busy = 0 next cycle, return to IDLE.
- Cycle counts:
  - init: N W0 cycles + 1 FIN.
  - march: 10N + 1 cycles + 1 FIN.
- Counter width is exactly ADDR_WIDTH; wrap-around is detected by terminal compare, not overflow.

Optional Feature:
- MEM_BIST_MARCH_EN defined: full behaviour above.
- Undefined: RD/WR/RONLY/DRAIN and the comparator are not built. mode is ignored, every start runs zero-init only, fail = 0 and fail_addr = 0 permanently.

Decomposition:
- Package mem_bist_pkg:
  - state enum (IDLE, W0, RD, WR, RONLY, DRAIN, FIN).
  - march element table: per element the direction, expected value and write-after-read flag.
  - constants MODE_INIT = 0, MODE_MARCH = 1.
- One sub-module, rw0_port_mux: selects functional vs BIST drive of RW0_* from busy.

Test Plan (ADDR_WIDTH = 4, N = 16, behavioural one-cycle-latency RAM model):
- Init: mode = 0, start at cycle 0 → busy from cycle 1, 16 writes of 0 at addr 0..15, done pulse at cycle 17, fail = 0; all 16 entries read back as 0.
- March, good RAM: mode = 1, start → done exactly 162 cycles after start, fail = 0; RW0 access sequence matches the element table, including descending 15..0 in elements 3 and 4.
- Fault: RAM bit 5 of addr 3 stuck at 1, March → fail = 1, fail_addr = 3 after element-1 read of addr 3; done pulse on the following FIN cycle; no further RW0_en after abort.
- Passthrough: idle, f_en = 1, f_wmode = 1, f_addr = 7, f_wdata = 0xA5.., mask = 0x0000000F → RW0_* mirror in the same cycle; a read of addr 7 returns the value on f_rdata next cycle. A functional access coinciding with start still executes.
- Robustness:
  - start while busy → ignored, no change in cycle count.
  - reset_n low at mid-element 3 → next cycle busy = 0, fail = 0, IDLE.
  - new start after a fail → fail clears in the cycle after start.
